// File: rtl/cdf_pkg.sv
// Shared constants, FSM encoding and index clamp for the connected-domain filter.
package cdf_pkg;

   localparam int unsigned ROW_W   = 512;
   localparam int unsigned IDX_W   = 9;
   localparam int unsigned IDX_MIN = 1;
   localparam int unsigned IDX_MAX = 510;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      TRIG = 2'd2,
      FIN  = 2'd3
   } state_t;

   // Limit an index to the mask generator's legal range.
   function automatic logic [IDX_W-1:0] clamp_idx(input logic [IDX_W-1:0] v);
      if (v < IDX_W'(IDX_MIN)) return IDX_W'(IDX_MIN);
      if (v > IDX_W'(IDX_MAX)) return IDX_W'(IDX_MAX);
      return v;
   endfunction

endpackage

// File: rtl/seg_first_last_enc.sv
// Finds the first and last set bit of a segment, position 0 being the MSB.
module seg_first_last_enc #(
   parameter int unsigned SEG_W = 32
) (
   input  logic [SEG_W-1:0]         seg,
   output logic                     any_one,
   output logic [$clog2(SEG_W)-1:0] first_pos,
   output logic [$clog2(SEG_W)-1:0] last_pos
);

   localparam int unsigned POS_W = $clog2(SEG_W);

   assign any_one = |seg;

   // Later iterations win, so scan toward the bit that should take priority.
   always_comb begin
      first_pos = '0;
      last_pos  = '0;
      for (int i = 0; i < int'(SEG_W); i++) begin
         if (seg[i]) first_pos = POS_W'(int'(SEG_W) - 1 - i);
      end
      for (int i = int'(SEG_W) - 1; i >= 0; i--) begin
         if (seg[i]) last_pos = POS_W'(int'(SEG_W) - 1 - i);
      end
   end

endmodule

// File: rtl/row_bound_finder_512bit.sv
// Scans a 512-bit row for its leftmost/rightmost set bit and hands the clamped
// bounds to the mask generator through the trig/done handshake.
module row_bound_finder_512bit
   import cdf_pkg::*;
#(
   parameter int unsigned SEG_W = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [ROW_W-1:0] i_row,
   output logic             o_busy,
   output logic             o_trig,
   input  logic             i_done,
   output logic [IDX_W-1:0] o_bound_index_left,
   output logic [IDX_W-1:0] o_bound_index_right,
   output logic             o_empty,
   output logic             o_finish
);

   localparam int unsigned NSEG  = ROW_W / SEG_W;
   localparam int unsigned CNT_W = $clog2(NSEG);
   localparam int unsigned POS_W = $clog2(SEG_W);

   state_t           state;
   logic [ROW_W-1:0] row_q;
   logic [CNT_W-1:0] seg_cnt;
   logic             found;

   logic             any_one;
   logic [POS_W-1:0] first_pos;
   logic [POS_W-1:0] last_pos;
   logic [IDX_W-1:0] base;
   logic [IDX_W-1:0] left_n;
   logic [IDX_W-1:0] right_n;
   logic             found_n;
   logic             last_seg;

   // The latched row shifts left, so the current segment is always at the top.
   seg_first_last_enc #(.SEG_W(SEG_W)) u_enc (
      .seg       (row_q[ROW_W-1 -: SEG_W]),
      .any_one   (any_one),
      .first_pos (first_pos),
      .last_pos  (last_pos)
   );

   always_comb begin
      base     = IDX_W'(seg_cnt) * IDX_W'(SEG_W);
      left_n   = (any_one && !found) ? base + IDX_W'(first_pos) : o_bound_index_left;
      right_n  = any_one ? base + IDX_W'(last_pos) : o_bound_index_right;
      found_n  = found | any_one;
      last_seg = (seg_cnt == CNT_W'(NSEG - 1));
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state               <= IDLE;
         row_q               <= '0;
         seg_cnt             <= '0;
         found               <= 1'b0;
         o_busy              <= 1'b0;
         o_trig              <= 1'b0;
         o_empty             <= 1'b0;
         o_finish            <= 1'b0;
         o_bound_index_left  <= '0;
         o_bound_index_right <= '0;
      end else begin
         o_finish <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  row_q               <= i_row;
                  seg_cnt             <= '0;
                  found               <= 1'b0;
                  o_empty             <= 1'b0;
                  o_busy              <= 1'b1;
                  o_bound_index_left  <= '0;
                  o_bound_index_right <= '0;
                  state               <= SCAN;
               end
            end
            SCAN: begin
               row_q   <= row_q << SEG_W;
               seg_cnt <= seg_cnt + CNT_W'(1);
               found   <= found_n;
               if (!last_seg) begin
                  o_bound_index_left  <= left_n;
                  o_bound_index_right <= right_n;
               end else if (found_n) begin
                  // An empty row keeps its zero indices; only real bounds are clamped.
                  o_bound_index_left  <= clamp_idx(left_n);
                  o_bound_index_right <= clamp_idx(right_n);
                  o_trig              <= 1'b1;
                  state               <= TRIG;
               end else begin
                  o_empty <= 1'b1;
                  state   <= FIN;
               end
            end
            TRIG: begin
               if (i_done) begin
                  o_trig <= 1'b0;
                  state  <= FIN;
               end
            end
            FIN: begin
               o_finish <= 1'b1;
               o_busy   <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_row_bound_finder_512bit.sv
// Random and directed bench for row_bound_finder_512bit at SEG_W = 32, 8 and 128.
module tb_row_bound_finder_512bit;

   logic         clk;
   logic         rst;
   logic         start  [3];
   logic [511:0] row    [3];
   logic         done   [3];
   logic         busy   [3];
   logic         trig   [3];
   logic [8:0]   left   [3];
   logic [8:0]   right  [3];
   logic         empty  [3];
   logic         finish [3];

   int n_chk  = 0;
   int n_fail = 0;

   row_bound_finder_512bit #(.SEG_W(32)) u_dut32 (
      .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_row(row[0]),
      .o_busy(busy[0]), .o_trig(trig[0]), .i_done(done[0]),
      .o_bound_index_left(left[0]), .o_bound_index_right(right[0]),
      .o_empty(empty[0]), .o_finish(finish[0]));

   row_bound_finder_512bit #(.SEG_W(8)) u_dut8 (
      .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_row(row[1]),
      .o_busy(busy[1]), .o_trig(trig[1]), .i_done(done[1]),
      .o_bound_index_left(left[1]), .o_bound_index_right(right[1]),
      .o_empty(empty[1]), .o_finish(finish[1]));

   row_bound_finder_512bit #(.SEG_W(128)) u_dut128 (
      .i_clk(clk), .i_rst(rst), .i_start(start[2]), .i_row(row[2]),
      .o_busy(busy[2]), .o_trig(trig[2]), .i_done(done[2]),
      .o_bound_index_left(left[2]), .o_bound_index_right(right[2]),
      .o_empty(empty[2]), .o_finish(finish[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int nseg_of(input int d);
      return (d == 0) ? 16 : (d == 1) ? 64 : 4;
   endfunction

   // Reference: scan all 512 indices for the outermost ones, then clamp to 1..510.
   function automatic void ref_bounds(input logic [511:0] r, output logic [8:0] l,
                                      output logic [8:0] rr, output bit emp);
      int f = -1;
      int la = -1;
      for (int i = 0; i < 512; i++) begin
         if (r[511 - i]) begin
            if (f < 0) f = i;
            la = i;
         end
      end
      emp = (f < 0);
      if (emp) begin
         l = 9'd0; rr = 9'd0;
      end else begin
         l  = 9'((f < 1) ? 1 : (f > 510) ? 510 : f);
         rr = 9'((la < 1) ? 1 : (la > 510) ? 510 : la);
      end
   endfunction

   function automatic logic [511:0] bit_at(input int idx);
      logic [511:0] v = '0;
      v[511 - idx] = 1'b1;
      return v;
   endfunction

   // One full operation; inj pulses a conflicting start in SCAN and in TRIG.
   task automatic run_op(input int d, input logic [511:0] r, input int dly, input bit inj);
      logic [8:0] el, er;
      bit emp;
      int n;
      int ns;
      ns = nseg_of(d);
      ref_bounds(r, el, er, emp);
      @(negedge clk);
      row[d]   = r;
      start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0;
      n = 0;
      check("busy_after_start", 32'(busy[d]), 32'd1);
      if (inj) row[d] = ~r;
      while (n < ns + 4 && !trig[d] && !finish[d]) begin
         start[d] = inj && (n == 3);
         @(negedge clk);
         n++;
      end
      start[d] = 1'b0;
      if (!emp) begin
         check("trig_latency", 32'(n), 32'(ns));
         check("left", 32'(left[d]), 32'(el));
         check("right", 32'(right[d]), 32'(er));
         if (inj) start[d] = 1'b1;
         for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            start[d] = 1'b0;
         end
         check("trig_held", 32'(trig[d]), 32'd1);
         check("left_held", 32'(left[d]), 32'(el));
         check("right_held", 32'(right[d]), 32'(er));
         done[d] = 1'b1;
         @(negedge clk);
         done[d] = 1'b0;
         check("trig_fall", 32'(trig[d]), 32'd0);
         check("finish_early", 32'(finish[d]), 32'd0);
         @(negedge clk);
         check("finish", 32'(finish[d]), 32'd1);
         check("busy_at_finish", 32'(busy[d]), 32'd0);
         check("empty_nonempty", 32'(empty[d]), 32'd0);
      end else begin
         check("fin_latency", 32'(n), 32'(ns + 1));
         check("trig_empty", 32'(trig[d]), 32'd0);
         check("empty_flag", 32'(empty[d]), 32'd1);
         check("left_empty", 32'(left[d]), 32'd0);
         check("right_empty", 32'(right[d]), 32'd0);
      end
   endtask

   task automatic check_reset_vals(input int d);
      check("rst_trig", 32'(trig[d]), 32'd0);
      check("rst_busy", 32'(busy[d]), 32'd0);
      check("rst_empty", 32'(empty[d]), 32'd0);
      check("rst_finish", 32'(finish[d]), 32'd0);
      check("rst_left", 32'(left[d]), 32'd0);
      check("rst_right", 32'(right[d]), 32'd0);
   endtask

   // Reset during SCAN (in_trig = 0) or while trig is held (in_trig = 1).
   task automatic reset_mid(input int d, input logic [511:0] r, input bit in_trig);
      int n;
      @(negedge clk);
      row[d]   = r;
      start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0;
      n = 0;
      while (n < 80 && (in_trig ? !trig[d] : n < 5)) begin
         @(negedge clk);
         n++;
      end
      if (in_trig) check("trig_before_rst", 32'(trig[d]), 32'd1);
      #2 rst = 1'b1;
      #1 check_reset_vals(d);
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [511:0] rand_row();
      logic [511:0] v = '0;
      case ($urandom_range(0, 3))
         0: v = '0;
         1: v = bit_at(int'($urandom_range(0, 511)));
         2: for (int k = 0; k < int'($urandom_range(1, 4)); k++)
               v |= bit_at(int'($urandom_range(0, 511)));
         default: for (int w = 0; w < 16; w++) v[32*w +: 32] = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      logic [511:0] r;
      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         start[d] = 1'b0; done[d] = 1'b0; row[d] = '0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) check_reset_vals(d);
      rst = 1'b0;

      run_op(0, bit_at(100) | bit_at(300), 3, 1'b0);
      run_op(0, bit_at(0), 2, 1'b0);
      run_op(0, bit_at(511), 1, 1'b0);
      run_op(0, '1, 1, 1'b0);
      run_op(0, '0, 1, 1'b0);
      r = bit_at(31) | bit_at(32) | bit_at(479);
      for (int d = 0; d < 3; d++) run_op(d, r, 2, 1'b0);
      run_op(0, bit_at(200) | bit_at(220), 3, 1'b1);
      run_op(1, bit_at(5) | bit_at(400), 2, 1'b1);

      reset_mid(0, bit_at(77) | bit_at(88), 1'b0);
      run_op(0, bit_at(77) | bit_at(88), 2, 1'b0);
      reset_mid(0, bit_at(10) | bit_at(500), 1'b1);
      run_op(0, bit_at(10) | bit_at(500), 2, 1'b0);

      for (int t = 0; t < 60; t++)
         run_op(t % 3, rand_row(), int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)));

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
